// File: rtl/alu_pkg.sv
// Shared definitions for the ALU-sharing block.
// Contents:
//   - ALU control codes as produced by alu_control (4-bit).
//   - OP_MAX: highest legal control code. Codes above it are rejected without using the ALU.
//   - state_e: arbiter FSM encoding (2-bit).
package alu_pkg;

    localparam logic [3:0] ADD  = 4'd0;
    localparam logic [3:0] SLL  = 4'd1;
    localparam logic [3:0] SLT  = 4'd2;
    localparam logic [3:0] SLTU = 4'd3;
    localparam logic [3:0] XOR  = 4'd4;
    localparam logic [3:0] SRL  = 4'd5;
    localparam logic [3:0] SRA  = 4'd6;
    localparam logic [3:0] OR   = 4'd7;
    localparam logic [3:0] AND  = 4'd8;
    localparam logic [3:0] SUB  = 4'd9;

    localparam int unsigned OP_MAX = 9;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StCapt  = 2'd2,
        StResp  = 2'd3
    } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant, purely combinational.
// Ports:
//   req [1:0] in  request lines
//   ptr       in  favoured requester when both request
//   gnt [1:0] out one-hot grant (all zero when nothing requests)
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt
);

    // A lone requester always wins; ptr only breaks ties.
    always_comb begin
        gnt    = 2'b00;
        gnt[0] = req[0] & (~req[1] | ~ptr);
        gnt[1] = req[1] & (~req[0] |  ptr);
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two requesters (req0 = execute, req1 = address/aux).
// A granted request is registered onto the ALU inputs, given one settle cycle, the ALU output
// is captured, and the response is held until the owning requester accepts it.
// Ports:
//   clk, rst                 clock, async active-high reset
//   req_valid/req_ready[1:0] request handshake per requester
//   req_op0/1, req_a0/1, req_b0/1  op code and operands per requester
//   rsp_valid/rsp_ready[1:0] response handshake, rsp_valid one-hot to owner
//   rsp_result, rsp_err      captured result and illegal-op flag (shared)
//   alu_op, alu_a, alu_b     registered drive to the shared ALU
//   alu_result               combinational ALU output
//   busy                     high whenever not idle
module alu_share_arbiter #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned OPW    = 4,
    parameter int unsigned OP_MAX = alu_pkg::OP_MAX
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      req_valid,
    output logic [1:0]      req_ready,
    input  logic [OPW-1:0]  req_op0,
    input  logic [OPW-1:0]  req_op1,
    input  logic [XLEN-1:0] req_a0,
    input  logic [XLEN-1:0] req_a1,
    input  logic [XLEN-1:0] req_b0,
    input  logic [XLEN-1:0] req_b1,
    output logic [1:0]      rsp_valid,
    input  logic [1:0]      rsp_ready,
    output logic [XLEN-1:0] rsp_result,
    output logic            rsp_err,
    output logic [OPW-1:0]  alu_op,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    input  logic [XLEN-1:0] alu_result,
    output logic            busy
);

    import alu_pkg::*;

    state_e          state_q, state_d;
    logic            rr_ptr_q, rr_ptr_d;
    logic            owner_q, owner_d;
    logic [OPW-1:0]  alu_op_q, alu_op_d;
    logic [XLEN-1:0] alu_a_q, alu_a_d;
    logic [XLEN-1:0] alu_b_q, alu_b_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            err_q, err_d;

    logic [1:0]      gnt;
    logic            handshake;
    logic            winner;
    logic [OPW-1:0]  win_op;
    logic [XLEN-1:0] win_a, win_b;

    rr_arb2 u_rr_arb2 (
        .req (req_valid),
        .ptr (rr_ptr_q),
        .gnt (gnt)
    );

    // Grant is only offered while idle; rst masks it so nothing handshakes during reset.
    assign req_ready = (state_q == StIdle && !rst) ? gnt : 2'b00;
    assign handshake = |(req_valid & req_ready);
    assign winner    = gnt[1];

    assign win_op = winner ? req_op1 : req_op0;
    assign win_a  = winner ? req_a1  : req_a0;
    assign win_b  = winner ? req_b1  : req_b0;

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        alu_op_d = alu_op_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        result_d = result_q;
        err_d    = err_q;

        unique case (state_q)
            StIdle: begin
                if (handshake) begin
                    owner_d = winner;
                    if (win_op > OPW'(OP_MAX)) begin
                        // Illegal code: answer straight away, ALU registers keep old values.
                        err_d    = 1'b1;
                        result_d = '0;
                        state_d  = StResp;
                    end else begin
                        alu_op_d = win_op;
                        alu_a_d  = win_a;
                        alu_b_d  = win_b;
                        state_d  = StIssue;
                    end
                end
            end
            StIssue: begin
                state_d = StCapt;
            end
            StCapt: begin
                result_d = alu_result;
                err_d    = 1'b0;
                state_d  = StResp;
            end
            StResp: begin
                if (rsp_ready[owner_q]) begin
                    rr_ptr_d = ~owner_q;
                    state_d  = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            rr_ptr_q <= 1'b0;
            owner_q  <= 1'b0;
            alu_op_q <= '0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            alu_op_q <= alu_op_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    assign rsp_valid  = (state_q == StResp) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_result = result_q;
    assign rsp_err    = err_q;
    assign alu_op     = alu_op_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [3:0]  req_op0, req_op1;
    logic [31:0] req_a0, req_a1, req_b0, req_b1;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_err;
    logic [3:0]  alu_op;
    logic [31:0] alu_a, alu_b;
    logic [31:0] alu_result;
    logic        busy;

    int checks = 0;
    int errors = 0;

    alu_share_arbiter #(
        .XLEN   (32),
        .OPW    (4),
        .OP_MAX (9)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op0    (req_op0),
        .req_op1    (req_op1),
        .req_a0     (req_a0),
        .req_a1     (req_a1),
        .req_b0     (req_b0),
        .req_b1     (req_b1),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the shared combinational ALU.
    always_comb begin
        alu_result = 32'h0;
        case (alu_op)
            4'd0: alu_result = alu_a + alu_b;
            4'd1: alu_result = alu_a << alu_b[4:0];
            4'd2: alu_result = {31'h0, $signed(alu_a) < $signed(alu_b)};
            4'd3: alu_result = {31'h0, alu_a < alu_b};
            4'd4: alu_result = alu_a ^ alu_b;
            4'd5: alu_result = alu_a >> alu_b[4:0];
            4'd6: alu_result = $unsigned($signed(alu_a) >>> alu_b[4:0]);
            4'd7: alu_result = alu_a | alu_b;
            4'd8: alu_result = alu_a & alu_b;
            4'd9: alu_result = alu_a - alu_b;
            default: alu_result = 32'h0;
        endcase
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic port, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b);
        if (port) begin
            req_op1 = op; req_a1 = a; req_b1 = b;
        end else begin
            req_op0 = op; req_a0 = a; req_b0 = b;
        end
    endtask

    // One complete transaction on a single requester, starting from idle.
    task automatic do_txn(input logic port, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res,
                          input logic exp_err, input int idx);
        logic [1:0] oh;
        logic [3:0] prev_op;
        int         k;
        int         lat;
        oh      = port ? 2'b10 : 2'b01;
        lat     = exp_err ? 1 : 3;
        prev_op = alu_op;
        set_req(port, op, a, b);
        req_valid = oh;
        #1;
        k = 0;
        while (req_ready[port] !== 1'b1 && k < 20) begin
            step();
            k++;
        end
        chk($sformatf("v%0d req_ready grant", idx), {30'h0, req_ready}, {30'h0, oh});
        step();
        req_valid = 2'b00;
        // Scramble operands: they must have been sampled at the handshake.
        set_req(port, 4'd0, 32'hDEAD_BEEF, 32'h1234_5678);
        chk($sformatf("v%0d busy after handshake", idx), {31'h0, busy}, 32'h1);
        if (!exp_err) begin
            chk($sformatf("v%0d alu_op issued", idx), {28'h0, alu_op}, {28'h0, op});
            chk($sformatf("v%0d alu_a issued", idx), alu_a, a);
            chk($sformatf("v%0d alu_b issued", idx), alu_b, b);
        end
        rsp_ready = ~oh;
        k = 1;
        while (rsp_valid === 2'b00 && k < 10) begin
            step();
            k++;
        end
        chk($sformatf("v%0d latency", idx), k, lat);
        step();
        chk($sformatf("v%0d rsp_valid", idx), {30'h0, rsp_valid}, {30'h0, oh});
        chk($sformatf("v%0d rsp_result", idx), rsp_result, exp_res);
        chk($sformatf("v%0d rsp_err", idx), {31'h0, rsp_err}, {31'h0, exp_err});
        if (exp_err)
            chk($sformatf("v%0d alu_op unchanged", idx), {28'h0, alu_op}, {28'h0, prev_op});
        rsp_ready = oh;
        step();
        rsp_ready = 2'b00;
        chk($sformatf("v%0d rsp_valid after accept", idx), {30'h0, rsp_valid}, 32'h0);
        chk($sformatf("v%0d busy after accept", idx), {31'h0, busy}, 32'h0);
    endtask

    typedef struct {
        logic        port;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        err;
    } vec_t;

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{1'b0, 4'd0, 32'd5,         32'd7,  32'd12,        1'b0};
        vecs[1]  = '{1'b0, 4'd9, 32'd10,        32'd3,  32'd7,         1'b0};
        vecs[2]  = '{1'b1, 4'd8, 32'hF0,        32'h3C, 32'h30,        1'b0};
        vecs[3]  = '{1'b1, 4'd7, 32'hF0,        32'h0F, 32'hFF,        1'b0};
        vecs[4]  = '{1'b0, 4'd4, 32'hFF,        32'h0F, 32'hF0,        1'b0};
        vecs[5]  = '{1'b1, 4'd1, 32'd1,         32'd4,  32'd16,        1'b0};
        vecs[6]  = '{1'b0, 4'd5, 32'h80,        32'd3,  32'h10,        1'b0};
        vecs[7]  = '{1'b1, 4'd6, 32'h8000_0000, 32'd4,  32'hF800_0000, 1'b0};
        vecs[8]  = '{1'b0, 4'd2, 32'hFFFF_FFFF, 32'd0,  32'd1,         1'b0};
        vecs[9]  = '{1'b1, 4'd3, 32'hFFFF_FFFF, 32'd0,  32'd0,         1'b0};
        vecs[10] = '{1'b1, 4'hB, 32'd9,         32'd9,  32'd0,         1'b1};
        vecs[11] = '{1'b0, 4'hF, 32'd1,         32'd2,  32'd0,         1'b1};

        rst = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        set_req(1'b0, 4'd0, 32'd0, 32'd0);
        set_req(1'b1, 4'd0, 32'd0, 32'd0);
        step();
        step();

        // Reset state, with both requesters asking.
        req_valid = 2'b11;
        #1;
        chk("reset req_ready", {30'h0, req_ready}, 32'h0);
        chk("reset rsp_valid", {30'h0, rsp_valid}, 32'h0);
        chk("reset busy", {31'h0, busy}, 32'h0);
        chk("reset alu_op", {28'h0, alu_op}, 32'h0);
        chk("reset rsp_result", rsp_result, 32'h0);
        req_valid = 2'b00;
        rst = 1'b0;
        step();

        // Both valid: req0 first, then req1.
        set_req(1'b0, 4'd9, 32'd10, 32'd3);
        set_req(1'b1, 4'd8, 32'hF0, 32'h3C);
        req_valid = 2'b11;
        #1;
        chk("both grant0", {30'h0, req_ready}, 32'h1);
        step();
        req_valid = 2'b10;
        chk("both issue ready", {30'h0, req_ready}, 32'h0);
        step();
        chk("both capt ready", {30'h0, req_ready}, 32'h0);
        step();
        chk("both rsp0 valid", {30'h0, rsp_valid}, 32'h1);
        chk("both rsp0 result", rsp_result, 32'd7);
        rsp_ready = 2'b01;
        step();
        rsp_ready = 2'b00;
        chk("both grant1", {30'h0, req_ready}, 32'h2);
        step();
        req_valid = 2'b00;
        step();
        step();
        chk("both rsp1 valid", {30'h0, rsp_valid}, 32'h2);
        chk("both rsp1 result", rsp_result, 32'h30);
        rsp_ready = 2'b10;
        step();
        rsp_ready = 2'b00;

        // Backpressure: owner 0 stalls 5 cycles while req1 waits.
        set_req(1'b0, 4'd0, 32'd100, 32'd23);
        set_req(1'b1, 4'd4, 32'hFF, 32'h0F);
        req_valid = 2'b11;
        #1;
        chk("bp grant0", {30'h0, req_ready}, 32'h1);
        step();
        req_valid = 2'b10;
        step();
        step();
        rsp_ready = 2'b10;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp hold%0d rsp_valid", i), {30'h0, rsp_valid}, 32'h1);
            chk($sformatf("bp hold%0d result", i), rsp_result, 32'd123);
            chk($sformatf("bp hold%0d req_ready", i), {30'h0, req_ready}, 32'h0);
            step();
        end
        rsp_ready = 2'b01;
        step();
        rsp_ready = 2'b00;
        chk("bp grant1 after accept", {30'h0, req_ready}, 32'h2);
        step();
        req_valid = 2'b00;
        step();
        step();
        chk("bp rsp1 valid", {30'h0, rsp_valid}, 32'h2);
        chk("bp rsp1 result", rsp_result, 32'hF0);
        rsp_ready = 2'b10;
        step();
        rsp_ready = 2'b00;

        // Table-driven single-requester transactions.
        for (int i = 0; i < 12; i++) begin
            do_txn(vecs[i].port, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].err, i);
        end

        // Reset during CAPT; first leave rr_ptr at 1.
        do_txn(1'b0, 4'd0, 32'd1, 32'd1, 32'd2, 1'b0, 100);
        set_req(1'b0, 4'd7, 32'd3, 32'd4);
        req_valid = 2'b01;
        #1;
        step();
        req_valid = 2'b00;
        step();
        chk("capt busy", {31'h0, busy}, 32'h1);
        rst = 1'b1;
        #1;
        chk("rst capt rsp_valid", {30'h0, rsp_valid}, 32'h0);
        chk("rst capt busy", {31'h0, busy}, 32'h0);
        chk("rst capt alu_op", {28'h0, alu_op}, 32'h0);
        chk("rst capt alu_a", alu_a, 32'h0);
        chk("rst capt alu_b", alu_b, 32'h0);
        chk("rst capt rsp_result", rsp_result, 32'h0);
        chk("rst capt rsp_err", {31'h0, rsp_err}, 32'h0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("post rst no rsp%0d", i), {30'h0, rsp_valid}, 32'h0);
            step();
        end

        // Continuous contention: grants alternate starting at req0 (rr_ptr back to 0).
        req_valid = 2'b11;
        for (int i = 0; i < 8; i++) begin
            logic [1:0]  eoh;
            logic [31:0] eres;
            set_req(1'b0, 4'd0, i, 32'd2);
            set_req(1'b1, 4'd9, 32'd50, i);
            eoh  = (i % 2 == 0) ? 2'b01 : 2'b10;
            eres = (i % 2 == 0) ? i + 2 : 50 - i;
            #1;
            chk($sformatf("alt%0d grant", i), {30'h0, req_ready}, {30'h0, eoh});
            chk($sformatf("alt%0d idle busy", i), {31'h0, busy}, 32'h0);
            step();
            chk($sformatf("alt%0d issue busy", i), {31'h0, busy}, 32'h1);
            step();
            chk($sformatf("alt%0d capt busy", i), {31'h0, busy}, 32'h1);
            step();
            chk($sformatf("alt%0d rsp_valid", i), {30'h0, rsp_valid}, {30'h0, eoh});
            chk($sformatf("alt%0d result", i), rsp_result, eres);
            chk($sformatf("alt%0d resp busy", i), {31'h0, busy}, 32'h1);
            rsp_ready = eoh;
            step();
            rsp_ready = 2'b00;
        end
        req_valid = 2'b00;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
